// File: rtl/contador_descendente_mod.sv
`default_nettype none
// ============================================================================
// Module      : contador_descendente_mod
// Description : Modulo-N down counter with load, enable, cascade TC and
//               one-shot (stop-at-zero) mode.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_descendente_mod #(
    parameter int WIDTH   = 3,
    parameter int MODULUS = 7
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic             MODE,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             TC,
    output logic             DONE,
    output logic             LOAD_ERR
);

    generate
        if ((MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_bad_modulus
            $error("contador_descendente_mod: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    localparam logic [WIDTH:0]   c_MOD  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    // DONE is the registered one-shot state itself.
    localparam logic [0:0] ST_COUNTING = 1'b0;
    localparam logic [0:0] ST_STOPPED  = 1'b1;

    logic [WIDTH-1:0] r_q;
    logic [0:0]       r_state;
    logic             r_load_err;
    logic             w_q_zero;
    logic             w_d_in_range;

    assign w_q_zero     = (r_q == c_ZERO);
    assign w_d_in_range = ({1'b0, D} < c_MOD);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_q        <= c_ZERO;
            r_state    <= ST_COUNTING;
            r_load_err <= 1'b0;
        end else begin
            r_load_err <= 1'b0;
            if (LOAD) begin
                // Out-of-range loads saturate to the top of the count range.
                if (w_d_in_range) begin
                    r_q <= D;
                end else begin
                    r_q        <= c_MAX;
                    r_load_err <= 1'b1;
                end
                r_state <= ST_COUNTING;
            end else if (EN) begin
                if (!w_q_zero) begin
                    r_q <= r_q - c_ONE;
                    if (MODE && (r_q == c_ONE)) begin
                        r_state <= ST_STOPPED;
                    end
                end else if (!MODE) begin
                    r_q <= c_MAX;
                end
            end
        end
    end

    assign Q        = r_q;
    assign DONE     = (r_state == ST_STOPPED);
    assign LOAD_ERR = r_load_err;
    assign TC       = EN & ~LOAD & ~MODE & w_q_zero;

endmodule
`default_nettype wire

// File: tb/tb_contador_descendente_mod.sv
`default_nettype none
// Self-checking bench for contador_descendente_mod (WIDTH=3, MODULUS=7).
module tb_contador_descendente_mod;

    typedef struct {
        logic       ld;
        logic       en;
        logic       md;
        logic [2:0] d;
        logic       tc;
        logic [2:0] q;
        logic       dn;
        logic       er;
    } vec_t;

    logic       CLK;
    logic       RESET;
    logic       EN;
    logic       LOAD;
    logic       MODE;
    logic [2:0] D;
    logic [2:0] Q;
    logic       TC;
    logic       DONE;
    logic       LOAD_ERR;

    int n_tests = 0;
    int n_fail  = 0;
    vec_t tbl[$];

    contador_descendente_mod #(.WIDTH(3), .MODULUS(7)) dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .LOAD(LOAD), .MODE(MODE),
        .D(D), .Q(Q), .TC(TC), .DONE(DONE), .LOAD_ERR(LOAD_ERR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic ld, input logic en, input logic md, input logic [2:0] d,
                       input logic tc, input logic [2:0] q, input logic dn, input logic er);
        vec_t v;
        v.ld = ld; v.en = en; v.md = md; v.d = d;
        v.tc = tc; v.q = q; v.dn = dn; v.er = er;
        tbl.push_back(v);
    endtask

    task automatic step_chk(input string tag, input logic [2:0] q, input logic dn, input logic er);
        @(posedge CLK);
        #1;
        check({tag, " Q"}, int'(Q), int'(q));
        check({tag, " DONE"}, int'(DONE), int'(dn));
        check({tag, " LOAD_ERR"}, int'(LOAD_ERR), int'(er));
    endtask

    initial begin
        //  ld en md d      tc  q    dn er
        // free run from reset
        add(0, 1, 0, 3'd0, 1, 3'd6, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd5, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd4, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd3, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd2, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd1, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        add(0, 1, 0, 3'd0, 1, 3'd6, 0, 0);
        add(0, 0, 0, 3'd0, 0, 3'd6, 0, 0);
        // in-range load with EN high, then count through wrap
        add(1, 1, 0, 3'd4, 0, 3'd4, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd3, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd2, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd1, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        add(0, 1, 0, 3'd0, 1, 3'd6, 0, 0);
        // out-of-range loads: single pulse, then back-to-back
        add(1, 0, 0, 3'd7, 0, 3'd6, 0, 1);
        add(0, 0, 0, 3'd0, 0, 3'd6, 0, 0);
        add(1, 0, 0, 3'd7, 0, 3'd6, 0, 1);
        add(1, 0, 0, 3'd7, 0, 3'd6, 0, 1);
        add(1, 0, 0, 3'd5, 0, 3'd5, 0, 0);
        // LOAD beats EN; TC masked by LOAD at Q=0
        add(1, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        add(1, 1, 0, 3'd2, 0, 3'd2, 0, 0);
        // one-shot
        add(1, 1, 1, 3'd3, 0, 3'd3, 0, 0);
        add(0, 1, 1, 3'd0, 0, 3'd2, 0, 0);
        add(0, 1, 1, 3'd0, 0, 3'd1, 0, 0);
        add(0, 1, 1, 3'd0, 0, 3'd0, 1, 0);
        add(0, 1, 1, 3'd0, 0, 3'd0, 1, 0);
        add(0, 1, 1, 3'd0, 0, 3'd0, 1, 0);
        add(1, 0, 1, 3'd2, 0, 3'd2, 0, 0);
        // MODE 1->0 at Q=0 wraps; DONE stays until a load
        add(0, 1, 1, 3'd0, 0, 3'd1, 0, 0);
        add(0, 1, 1, 3'd0, 0, 3'd0, 1, 0);
        add(0, 1, 0, 3'd0, 1, 3'd6, 1, 0);
        add(0, 1, 0, 3'd0, 0, 3'd5, 1, 0);
        add(1, 0, 0, 3'd1, 0, 3'd1, 0, 0);
        add(0, 1, 0, 3'd0, 0, 3'd0, 0, 0);
        add(0, 0, 1, 3'd0, 0, 3'd0, 0, 0);
        add(1, 0, 0, 3'd6, 0, 3'd6, 0, 0);

        RESET = 1'b1; EN = 1'b0; LOAD = 1'b0; MODE = 1'b0; D = 3'd0;
        #2;
        check("reset Q", int'(Q), 0);
        check("reset DONE", int'(DONE), 0);
        check("reset LOAD_ERR", int'(LOAD_ERR), 0);
        check("reset TC", int'(TC), 0);
        #8;
        RESET = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            LOAD = tbl[i].ld; EN = tbl[i].en; MODE = tbl[i].md; D = tbl[i].d;
            #1;
            check($sformatf("vec%0d TC", i), int'(TC), int'(tbl[i].tc));
            step_chk($sformatf("vec%0d", i), tbl[i].q, tbl[i].dn, tbl[i].er);
        end

        // Async reset clears a pending LOAD_ERR pulse without an edge
        LOAD = 1'b1; EN = 1'b0; MODE = 1'b0; D = 3'd7;
        step_chk("err pre", 3'd6, 1'b0, 1'b1);
        LOAD = 1'b0;
        #3 RESET = 1'b1;
        #1;
        check("async err Q", int'(Q), 0);
        check("async err LOAD_ERR", int'(LOAD_ERR), 0);
        #2 RESET = 1'b0;

        // Async reset mid-count at Q=4, inputs ignored while held
        LOAD = 1'b1; D = 3'd4;
        step_chk("mid pre", 3'd4, 1'b0, 1'b0);
        LOAD = 1'b0;
        #3 RESET = 1'b1;
        #1;
        check("mid async Q", int'(Q), 0);
        LOAD = 1'b1; EN = 1'b1; D = 3'd5;
        step_chk("mid held", 3'd0, 1'b0, 1'b0);
        #3;
        RESET = 1'b0; LOAD = 1'b0; EN = 1'b1; MODE = 1'b0;
        step_chk("mid release", 3'd6, 1'b0, 1'b0);

        // Idle after reset in one-shot mode
        #2 RESET = 1'b1;
        #4 RESET = 1'b0;
        MODE = 1'b1; EN = 1'b1; LOAD = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            check($sformatf("idle%0d TC", k), int'(TC), 0);
            step_chk($sformatf("idle%0d", k), 3'd0, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
